// File: rtl/hazard_requester_pkg.sv
// Shared types for the hazard requester: memory access classes, the
// per-stage metadata record, flush FSM states and the hazard bus payloads.
package riscv_defines;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } mem_access_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        regwrite;
    mem_access_t memaccess;
  } stage_meta_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    ACK   = 2'd2
  } flush_state_t;

  // Bubble: invalid, no register traffic, no memory access (MEM_NONE == 0).
  localparam stage_meta_t STAGE_BUBBLE = '0;

  typedef struct packed {
    logic [4:0]  rs1_d;
    logic [4:0]  rs2_d;
    logic [4:0]  rs1_e;
    logic [4:0]  rs2_e;
    logic [4:0]  rd_e;
    mem_access_t memaccess_e;
    logic        regwrite_m;
    logic [4:0]  rd_m;
    logic [4:0]  rs2_m;
    mem_access_t memaccess_m;
    logic        regwrite_w;
    logic [4:0]  rd_w;
    logic        mispredict;
    logic        flushflag;
  } hazard_req_t;

  typedef struct packed {
    logic raw_data;
    logic load_use;
    logic store_data;
    logic mispredict;
  } hazard_cause_t;

  typedef struct packed {
    logic          flush_e;
    logic          flush_m;
    hazard_cause_t hazard_cause;
  } hazard_res_t;

  // Builds the E-stage record from decode; an invalid slot never writes a
  // register nor touches memory, whatever decode left on those lines.
  function automatic stage_meta_t make_meta(
    input logic        valid,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [4:0]  rd,
    input logic        regwrite,
    input mem_access_t memaccess
  );
    stage_meta_t m;
    m.valid     = valid;
    m.rs1       = rs1;
    m.rs2       = rs2;
    m.rd        = rd;
    m.regwrite  = regwrite & valid;
    m.memaccess = valid ? memaccess : MEM_NONE;
    return m;
  endfunction

endpackage

// File: rtl/hazard_requester_if.sv
// Hazard bus between the pipeline (requester) and the hazard unit (resolver).
interface hazard_interface;
  import riscv_defines::*;

  hazard_req_t req;
  hazard_res_t res;

  modport requester (output req, input res);
  modport resolver  (input req, output res);

endinterface

// File: rtl/hazard_requester_event_counter.sv
// Single saturating event counter; clear wins over increment.
module hazard_event_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear, else saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_requester.sv
// Pipeline-side hazard requester: tracks E/M/W hazard metadata, drives the
// hazard request bus, applies resolver flushes to its own stage registers,
// sequences trap/fence flushes and counts hazard events per cause.
module hazard_requester
  import riscv_defines::*;
#(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  hazard_interface.requester  hazard_bus,
  input  logic                valid_d,
  input  logic [4:0]          rs1_d,
  input  logic [4:0]          rs2_d,
  input  logic [4:0]          rd_d,
  input  logic                regwrite_d,
  input  mem_access_t         memaccess_d,
  input  logic                mispredict_e,
  input  logic                flush_req,
  output logic                flush_ack,
  input  logic                cnt_clear,
  output logic [CNT_W-1:0]    cnt_raw_data,
  output logic [CNT_W-1:0]    cnt_load_use,
  output logic [CNT_W-1:0]    cnt_store_data,
  output logic [CNT_W-1:0]    cnt_mispredict
);

  localparam int unsigned FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  stage_meta_t  e_q, e_d;
  stage_meta_t  m_q, m_d;
  stage_meta_t  w_q, w_d;
  flush_state_t state_q, state_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic         flushflag;

  // Stage advance: resolver flushes replace the incoming record with a bubble.
  always_comb begin
    e_d = hazard_bus.res.flush_e ? STAGE_BUBBLE
                                 : make_meta(valid_d, rs1_d, rs2_d, rd_d,
                                             regwrite_d, memaccess_d);
    m_d = hazard_bus.res.flush_m ? STAGE_BUBBLE : e_q;
    w_d = m_q;
  end

  // E/M/W stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q <= STAGE_BUBBLE;
      m_q <= STAGE_BUBBLE;
      w_q <= STAGE_BUBBLE;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  // Flush FSM next state and outputs; requests are only sampled in IDLE.
  always_comb begin
    state_d   = state_q;
    fcnt_d    = fcnt_q;
    flushflag = 1'b0;
    flush_ack = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (flush_req) begin
          state_d = FLUSH;
          fcnt_d  = FCW'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        flushflag = 1'b1;
        if (fcnt_q == '0) begin
          state_d = ACK;
        end else begin
          fcnt_d = fcnt_q - FCW'(1);
        end
      end
      ACK: begin
        flush_ack = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Flush FSM state and hold counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Request bus: purely combinational from stage registers and decode inputs.
  always_comb begin
    hazard_bus.req             = '0;
    hazard_bus.req.rs1_d       = rs1_d;
    hazard_bus.req.rs2_d       = rs2_d;
    hazard_bus.req.rs1_e       = e_q.rs1;
    hazard_bus.req.rs2_e       = e_q.rs2;
    hazard_bus.req.rd_e        = e_q.rd;
    hazard_bus.req.memaccess_e = e_q.memaccess;
    hazard_bus.req.regwrite_m  = m_q.regwrite & m_q.valid;
    hazard_bus.req.rd_m        = m_q.rd;
    hazard_bus.req.rs2_m       = m_q.rs2;
    hazard_bus.req.memaccess_m = m_q.memaccess;
    hazard_bus.req.regwrite_w  = w_q.regwrite & w_q.valid;
    hazard_bus.req.rd_w        = w_q.rd;
    hazard_bus.req.mispredict  = mispredict_e & e_q.valid;
    hazard_bus.req.flushflag   = flushflag;
  end

  // W keeps the full record for traceability; only rd/regwrite leave the block.
  logic unused_meta;
  assign unused_meta = ^{m_q.rs1, w_q.rs1, w_q.rs2, w_q.memaccess};

  hazard_event_counter #(.CNT_W(CNT_W)) u_cnt_raw_data (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hazard_bus.res.hazard_cause.raw_data),
    .clr   (cnt_clear),
    .cnt   (cnt_raw_data)
  );

  hazard_event_counter #(.CNT_W(CNT_W)) u_cnt_load_use (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hazard_bus.res.hazard_cause.load_use),
    .clr   (cnt_clear),
    .cnt   (cnt_load_use)
  );

  hazard_event_counter #(.CNT_W(CNT_W)) u_cnt_store_data (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hazard_bus.res.hazard_cause.store_data),
    .clr   (cnt_clear),
    .cnt   (cnt_store_data)
  );

  hazard_event_counter #(.CNT_W(CNT_W)) u_cnt_mispredict (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hazard_bus.res.hazard_cause.mispredict),
    .clr   (cnt_clear),
    .cnt   (cnt_mispredict)
  );

endmodule
